// File: rtl/div_iter_unit_pkg.sv
// Shared encodings for the iterative divider: FSM states, handshake levels, zero word.
package div_iter_unit_pkg;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic        DivStart          = 1'b1;
  localparam logic        DivStop           = 1'b0;
  localparam logic        DivResultReady    = 1'b1;
  localparam logic        DivResultNotReady = 1'b0;
  localparam logic [31:0] ZeroWord          = 32'h0000_0000;
endpackage

// File: rtl/div_iter_unit_if.sv
// EX <-> divider start/ready handshake; EX is the master, the divider the slave.
interface div_iter_unit_if #(parameter int WIDTH = 32);
  logic                 signed_div_i;
  logic [WIDTH-1:0]     opdata1_i;
  logic [WIDTH-1:0]     opdata2_i;
  logic                 start_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;

  modport master (output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
                  input  result_o, ready_o);
  modport slave  (input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
                  output result_o, ready_o);
endinterface

// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider, one quotient bit per clock; result is {remainder, quotient}.
module div_iter_unit
  import div_iter_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            resetn,
  div_iter_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  div_state_e         r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_rem, w_rem_nxt;
  logic [WIDTH-1:0]   r_dvd, w_dvd_nxt;
  logic [WIDTH-1:0]   r_dvs, w_dvs_nxt;
  logic               r_sgn, w_sgn_nxt;
  logic               r_n1, w_n1_nxt;
  logic               r_n2, w_n2_nxt;
  logic [2*WIDTH-1:0] r_result, w_result_nxt;
  logic               r_ready, w_ready_nxt;

  // Magnitudes of the incoming operands; the signed minimum maps onto itself as unsigned.
  logic               w_op1_neg, w_op2_neg;
  logic [WIDTH-1:0]   w_op1_abs, w_op2_abs;
  assign w_op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign w_op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign w_op1_abs = w_op1_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
  assign w_op2_abs = w_op2_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

  // One iteration: shifted remainder needs WIDTH+1 bits before the trial subtract.
  logic [WIDTH:0]     w_up;
  logic               w_ge;
  logic [WIDTH-1:0]   w_sub, w_rem_it, w_quo_it, w_rem_fix, w_quo_fix;
  logic               w_last;
  assign w_up      = {r_rem, r_dvd[WIDTH-1]};
  assign w_ge      = (w_up >= {1'b0, r_dvs});
  assign w_sub     = w_up[WIDTH-1:0] - r_dvs;
  assign w_rem_it  = w_ge ? w_sub : w_up[WIDTH-1:0];
  assign w_quo_it  = {r_dvd[WIDTH-2:0], w_ge};
  assign w_quo_fix = (r_sgn & (r_n1 ^ r_n2)) ? (~w_quo_it + 1'b1) : w_quo_it;
  assign w_rem_fix = (r_sgn & r_n1) ? (~w_rem_it + 1'b1) : w_rem_it;
  assign w_last    = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rem_nxt    = r_rem;
    w_dvd_nxt    = r_dvd;
    w_dvs_nxt    = r_dvs;
    w_sgn_nxt    = r_sgn;
    w_n1_nxt     = r_n1;
    w_n2_nxt     = r_n2;
    w_result_nxt = r_result;
    w_ready_nxt  = r_ready;
    unique case (r_state)
      DivFree: begin
        w_ready_nxt = DivResultNotReady;
        if (bus.start_i == DivStart && !bus.annul_i) begin
          w_sgn_nxt   = bus.signed_div_i;
          w_n1_nxt    = w_op1_neg;
          w_n2_nxt    = w_op2_neg;
          w_dvd_nxt   = w_op1_abs;
          w_dvs_nxt   = w_op2_abs;
          w_rem_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = (bus.opdata2_i == '0) ? DivByZero : DivOn;
        end
      end
      DivByZero: begin
        if (bus.annul_i) begin
          w_state_nxt = DivFree;
          w_ready_nxt = DivResultNotReady;
        end else begin
          w_result_nxt = '0;
          w_state_nxt  = DivEnd;
        end
      end
      DivOn: begin
        if (bus.annul_i) begin
          w_state_nxt = DivFree;
          w_ready_nxt = DivResultNotReady;
        end else begin
          w_rem_nxt = w_rem_it;
          w_dvd_nxt = w_quo_it;
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_last) begin
            w_result_nxt = {w_rem_fix, w_quo_fix};
            w_state_nxt  = DivEnd;
          end
        end
      end
      DivEnd: begin
        // Ready follows END by one edge, so a flushed op never raises it.
        if (bus.start_i == DivStop) begin
          w_ready_nxt = DivResultNotReady;
          w_state_nxt = DivFree;
        end else begin
          w_ready_nxt = DivResultReady;
        end
      end
      default: w_state_nxt = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= DivFree;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_sgn    <= 1'b0;
      r_n1     <= 1'b0;
      r_n2     <= 1'b0;
      r_result <= '0;
      r_ready  <= DivResultNotReady;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rem    <= w_rem_nxt;
      r_dvd    <= w_dvd_nxt;
      r_dvs    <= w_dvs_nxt;
      r_sgn    <= w_sgn_nxt;
      r_n1     <= w_n1_nxt;
      r_n2     <= w_n2_nxt;
      r_result <= w_result_nxt;
      r_ready  <= w_ready_nxt;
    end
  end

  assign bus.result_o = r_result;
  assign bus.ready_o  = r_ready;
endmodule

// File: tb/tb_div_iter_unit.sv
// Scoreboard bench for div_iter_unit: directed operands, result and ready-latency checked by a monitor.
module tb_div_iter_unit;
  logic clk;
  logic resetn;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [63:0] res;
    int          cyc;
    string       nm;
  } exp_t;
  exp_t sb[$];

  div_iter_unit_if #(.WIDTH(32)) bus ();
  div_iter_unit #(.WIDTH(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every rising ready_o must match the oldest expected response.
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (resetn && bus.ready_o && !prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_ready", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk({e.nm, "_result"}, bus.result_o, e.res);
          chk({e.nm, "_latency"}, 64'(cyc), 64'(e.cyc));
        end
      end
      prev = resetn ? bus.ready_o : 1'b0;
    end
  end

  // Called at a negedge with the unit in FREE.
  task automatic do_op(input string nm, input logic sg, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input int lat);
    exp_t e;
    bus.signed_div_i = sg;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    @(negedge clk);
    e.res = exp; e.cyc = cyc + lat; e.nm = nm;
    sb.push_back(e);
    bus.signed_div_i = ~sg;
    bus.opdata1_i    = ~a;
    bus.opdata2_i    = 32'h0;
    for (int i = 0; i < 100 && !bus.ready_o; i++) @(negedge clk);
    if (!bus.ready_o) chk({nm, "_timeout"}, 64'd0, 64'd1);
    repeat (2) begin
      @(negedge clk);
      chk({nm, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
      chk({nm, "_hold_result"}, bus.result_o, exp);
    end
    bus.start_i = 1'b0;
    @(negedge clk);
    chk({nm, "_ready_drop"}, 64'(bus.ready_o), 64'd0);
    chk({nm, "_result_keep"}, bus.result_o, exp);
  endtask

  task automatic quiet_window(input string nm, input int n);
    int hi;
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.ready_o) hi++;
    end
    chk({nm, "_no_ready"}, 64'(hi), 64'd0);
  endtask

  initial begin
    resetn           = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    #1 resetn = 1'b0;
    #2;
    chk("reset_ready_async", 64'(bus.ready_o), 64'd0);
    chk("reset_result_async", bus.result_o, 64'd0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("reset_ready", 64'(bus.ready_o), 64'd0);

    do_op("u100_7",  1'b0, 32'd100,       32'd7,        64'h00000002_0000000E, 33);
    do_op("s-7_2",   1'b1, 32'hFFFFFFF9,  32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
    do_op("s7_-2",   1'b1, 32'h00000007,  32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    do_op("smin_-1", 1'b1, 32'h80000000,  32'hFFFFFFFF, 64'h00000000_80000000, 33);
    do_op("umax_1",  1'b0, 32'hFFFFFFFF,  32'h00000001, 64'h00000000_FFFFFFFF, 33);
    do_op("s-100_-7",1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 33);
    do_op("u5_0",    1'b0, 32'd5,         32'd0,        64'h00000000_00000000, 2);

    // Annul partway through the iterations.
    bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    @(negedge clk);
    repeat (9) @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.annul_i = 1'b0;
    quiet_window("annul", 40);
    do_op("u9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33);

    // Flush: start dropped while iterating.
    bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd20; bus.opdata2_i = 32'd3;
    bus.start_i = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    bus.start_i = 1'b0;
    quiet_window("flush", 40);

    // Asynchronous reset between edges mid-iteration.
    bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
    bus.start_i = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_ready", 64'(bus.ready_o), 64'd0);
    chk("midrst_result", bus.result_o, 64'd0);
    bus.start_i = 1'b0;
    #1 resetn = 1'b1;
    @(negedge clk);
    do_op("u8_2", 1'b0, 32'd8, 32'd2, 64'h00000000_00000004, 33);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
